// File: rtl/updown_pkg.sv
// Shared types and helpers for the parameterised up/down counter.
// Holds the count-mode enum and the parameter legality check.
package updown_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  function automatic bit params_ok(
    input int width,
    input int modulus,
    input int saturate
  );
    return (width >= 2) && (width <= 16) &&
           (modulus >= 2) &&
           (modulus <= (1 << width)) &&
           (saturate == 0 || saturate == 1);
  endfunction

endpackage

// File: rtl/updown_next.sv
// Next-state logic for the up/down counter: count, carry, borrow.
// Pure combinational; the top level owns every register.
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_next,
  output logic             carry_next,
  output logic             borrow_next
);

  localparam mode_e MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic do_load;
  logic do_up;
  logic do_down;

  assign do_load = load;
  assign do_up   = !load && en && up && !down;
  assign do_down = !load && en && down && !up;

  always_comb begin
    count_next  = count;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    unique case (1'b1)
      do_load: begin
        if ({1'b0, load_val} < MOD)
          count_next = load_val;
        else
          count_next = MAX;
      end
      do_up: begin
        if (count == MAX) begin
          carry_next = 1'b1;
          if (MODE == MODE_WRAP)
            count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      do_down: begin
        if (count == '0) begin
          borrow_next = 1'b1;
          if (MODE == MODE_WRAP)
            count_next = MAX;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with load, wrap/saturate modes
// and registered carry/borrow pulses.
module updown_counter_param
  import updown_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);

  if (!params_ok(WIDTH, MODULUS, SATURATE)) begin : g_bad_params
    $error("updown_counter_param: illegal WIDTH/MODULUS/SATURATE");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_next;
  logic             carry_next;
  logic             borrow_next;

  updown_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count       (count),
    .en          (en),
    .up          (up),
    .down        (down),
    .load        (load),
    .load_val    (load_val),
    .count_next  (count_next),
    .carry_next  (carry_next),
    .borrow_next (borrow_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      count  <= count_next;
      carry  <= carry_next;
      borrow <= borrow_next;
    end
  end

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: wrap and saturate counters share one stimulus
// stream and are checked against an arithmetic reference model.
module tb_updown_counter_param;

  localparam int W   = 3;
  localparam int MOD = 6;

  typedef struct {
    int c;
    bit cy;
    bit bw;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en, up, down, load;
  logic [W-1:0] load_val;

  logic [W-1:0] count0, count1;
  logic         carry0, carry1;
  logic         borrow0, borrow1;
  logic         at_max0, at_max1;
  logic         at_zero0, at_zero1;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  int   m0 = 0;
  int   m1 = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(W), .MODULUS(MOD), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .down(down),
    .load(load), .load_val(load_val), .count(count0), .carry(carry0),
    .borrow(borrow0), .at_max(at_max0), .at_zero(at_zero0)
  );

  updown_counter_param #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .down(down),
    .load(load), .load_val(load_val), .count(count1), .carry(carry1),
    .borrow(borrow1), .at_max(at_max1), .at_zero(at_zero1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int c, input bit sat,
                                 input bit l, input bit e, input bit u,
                                 input bit d, input int lv);
    exp_t r;
    r.c = c; r.cy = 1'b0; r.bw = 1'b0;
    if (l) begin
      r.c = (lv < MOD) ? lv : MOD - 1;
    end else if (e && u && !d) begin
      r.cy = (c == MOD - 1);
      r.c  = sat ? ((c + 1 > MOD - 1) ? MOD - 1 : c + 1) : (c + 1) % MOD;
    end else if (e && d && !u) begin
      r.bw = (c == 0);
      r.c  = sat ? ((c - 1 < 0) ? 0 : c - 1) : (c - 1 + MOD) % MOD;
    end
    return r;
  endfunction

  // Drive one cycle of stimulus (called just after a falling edge).
  task automatic step(input bit l, input bit e, input bit u,
                      input bit d, input int lv);
    exp_t r0, r1;
    load = l; en = e; up = u; down = d; load_val = W'(lv);
    r0 = model(m0, 1'b0, l, e, u, d, lv);
    r1 = model(m1, 1'b1, l, e, u, d, lv);
    m0 = r0.c; m1 = r1.c;
    q0.push_back(r0);
    q1.push_back(r1);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e0, e1;
    #1;
    if (mon_en && q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("wrap_count",   int'(count0),   e0.c);
      chk("wrap_carry",   int'(carry0),   int'(e0.cy));
      chk("wrap_borrow",  int'(borrow0),  int'(e0.bw));
      chk("wrap_at_max",  int'(at_max0),  int'(e0.c == MOD - 1));
      chk("wrap_at_zero", int'(at_zero0), int'(e0.c == 0));
      chk("sat_count",    int'(count1),   e1.c);
      chk("sat_carry",    int'(carry1),   int'(e1.cy));
      chk("sat_borrow",   int'(borrow1),  int'(e1.bw));
      chk("sat_at_max",   int'(at_max1),  int'(e1.c == MOD - 1));
      chk("sat_at_zero",  int'(at_zero1), int'(e1.c == 0));
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_count0"},  int'(count0),   0);
    chk({tag, "_carry0"},  int'(carry0),   0);
    chk({tag, "_borrow0"}, int'(borrow0),  0);
    chk({tag, "_atmax0"},  int'(at_max0),  0);
    chk({tag, "_atzero0"}, int'(at_zero0), 1);
    chk({tag, "_count1"},  int'(count1),   0);
    chk({tag, "_carry1"},  int'(carry1),   0);
    chk({tag, "_borrow1"}, int'(borrow1),  0);
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; load_val = '0;
    #1;
    chk_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);

    step(1, 1, 0, 0, 7);
    step(1, 1, 1, 0, 2);

    step(1, 0, 0, 0, 3);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);

    step(1, 0, 0, 0, 4);
    #2;
    reset_n = 1'b0;
    #1;
    m0 = 0; m1 = 0;
    chk_reset("midreset");
    #1;
    reset_n = 1'b1;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)));
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);

    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 8: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundaries, 1 = saturate at the boundaries.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable; gates up and down only, not load.
REQ-007 up  input  1  increment request.
REQ-008 down  input  1  decrement request.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 carry  output  1  registered one-cycle pulse on an up-wrap or up-saturation event.
REQ-013 borrow  output  1  registered one-cycle pulse on a down-wrap or down-saturation event.
REQ-014 at_max  output  1  combinational; high while count == MODULUS-1.
REQ-015 at_zero  output  1  combinational; high while count == 0.

Function
REQ-016 Per-edge priority SHALL be: load, then hold, then up, then down.
- Hold applies when en=0, when up=down=0, or when up=down=1.
REQ-017 Load SHALL set count = load_val when load_val < MODULUS, and count = MODULUS-1 otherwise.
- A load never asserts carry or borrow.
REQ-018 Up with count < MODULUS-1 SHALL set count = count+1, with carry=0.
REQ-019 Up with count == MODULUS-1 SHALL behave as follows, with carry=1 for exactly that next cycle:
- SATURATE=0: count becomes 0.
- SATURATE=1: count holds.
REQ-020 Down with count > 0 SHALL set count = count-1, with borrow=0.
REQ-021 Down with count == 0 SHALL behave as follows, with borrow=1 for exactly that next cycle:
- SATURATE=0: count becomes MODULUS-1.
- SATURATE=1: count holds at 0.
REQ-022 carry and borrow SHALL be 0 on every edge that does not meet REQ-019 or REQ-021; they are never both 1.
REQ-023 Latency SHALL be one clock from a sampled input to count, carry and borrow.
REQ-024 Boundary decisions SHALL use the registered count only, not a shadow copy.
REQ-025 Arithmetic SHALL be WIDTH bits wide, with no intermediate overflow for any legal MODULUS.
REQ-026 Continuous up, or continuous down, with en=1 SHALL cycle or saturate without any dead cycle.

Reset
REQ-027 reset_n=0 SHALL immediately force count=0, carry=0 and borrow=0, independent of clk.
- at_max=0 and at_zero=1 follow combinationally.
REQ-028 Reset asserted mid-count or mid-load SHALL abort the operation; no pulse survives the reset.
REQ-029 The first rising edge after reset_n deasserts SHALL be processed normally.

Structure
REQ-030 Shared package updown_pkg SHALL hold:
- a count-mode enum (MODE_WRAP, MODE_SAT);
- a parameter-legality check function.
REQ-031 Illegal parameter combinations SHALL fail at elaboration.
REQ-032 One sub-module, updown_next, SHALL compute next count, carry and borrow combinationally; the top level holds all registers.

Verification
(All scenarios use WIDTH=3, MODULUS=6, SATURATE=0 unless stated.)
REQ-033 reset_n low, then high; 7 edges of up, en=1 -> count 1,2,3,4,5,0,1; carry=1 only in the cycle count=0.
REQ-034 From count=0, 2 edges of down -> count 5 with borrow=1 for one cycle, then count 4 with borrow=0.
REQ-035 load=1 with load_val=7 -> count=5, at_max=1, carry=0; then load with up=1, load_val=2 -> count=2.
REQ-036 Hold cases: up=down=1 at count=3 holds count=3; en=0 with up=1 holds; no pulses in either case.
REQ-037 SATURATE=1: up for 8 edges from 0 -> count stops at 5 with carry=1 on each saturated edge; down at 0 -> borrow=1, count stays 0.
REQ-038 reset_n pulsed low between edges at count=4 -> count=0 immediately, carry=borrow=0; counting resumes from 0 on the next edge.
